// File: rtl/sensor_input_conditioner.sv
// rtl/sensor_input_conditioner.sv - synchronise, debounce and qualify sensor and button inputs
// Eight channels share one sample prescaler; channels [5:0] are sensors, [7:6] are buttons.
module sensor_input_conditioner #(
  parameter int SAMPLE_DIV     = 1024,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] raw_sensors,
  input  logic [1:0] raw_buttons,
  output logic [5:0] stable_sensors,
  output logic       sensor_changed,
  output logic [1:0] button_pressed,
  output logic       water_conflict,
  output logic       sample_tick
);

  localparam int NCH = 8;
  localparam int PW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW  = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_TICKS - 1);

  logic [NCH-1:0] sync_meta;
  logic [NCH-1:0] sync_q;
  logic [PW-1:0]  presc;
  logic           tick;
  logic [NCH-1:0] stable;
  logic [NCH-1:0] stable_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {raw_buttons, raw_sensors};
      sync_q    <= sync_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick        = (presc == PRESC_LAST);
  // Gated so the strobe is low during reset even when SAMPLE_DIV=1 keeps presc at its last value.
  assign sample_tick = tick & reset_n;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic          stable_bit;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        stable_bit <= 1'b0;
        cnt        <= '0;
      end else if (tick) begin
        if (sync_q[g] == stable_bit) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stable_bit <= sync_q[g];
          cnt        <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign stable[g] = stable_bit;
  end

  // Delayed copy marks the first cycle a new debounced value is visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  assign stable_sensors = stable[5:0];
  assign sensor_changed = |(stable[5:0] ^ stable_d[5:0]);
  assign button_pressed = stable[7:6] & ~stable_d[7:6];

  // Water levels: bit0 low, bit1 mid, bit2 high; a higher level wet with a lower one dry is inconsistent.
  assign water_conflict = (stable[2] & ~stable[1]) |
                          (stable[1] & ~stable[0]) |
                          (stable[2] & ~stable[0]);

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// tb/tb_sensor_input_conditioner.sv - randomized and directed bench for sensor_input_conditioner
// Reference model: raw history plus per-tick sample list; a bit flips when its last DEBOUNCE_TICKS samples all differ.
module tb_sensor_input_conditioner;

  localparam int SD = 4;
  localparam int DT = 3;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic [5:0] raw_sensors;
  logic [1:0] raw_buttons;
  logic [5:0] stable_sensors;
  logic       sensor_changed;
  logic [1:0] button_pressed;
  logic       water_conflict;
  logic       sample_tick;

  logic       reset_b_n;
  logic [5:0] raw_b;
  logic [5:0] stable_b;
  logic       changed_b;
  logic [1:0] pressed_b;
  logic       conflict_b;
  logic       tick_b;

  sensor_input_conditioner #(.SAMPLE_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clock(clock), .reset_n(reset_n), .raw_sensors(raw_sensors), .raw_buttons(raw_buttons),
    .stable_sensors(stable_sensors), .sensor_changed(sensor_changed), .button_pressed(button_pressed),
    .water_conflict(water_conflict), .sample_tick(sample_tick)
  );

  sensor_input_conditioner #(.SAMPLE_DIV(1), .DEBOUNCE_TICKS(1)) dut_fast (
    .clock(clock), .reset_n(reset_b_n), .raw_sensors(raw_b), .raw_buttons(2'b00),
    .stable_sensors(stable_b), .sensor_changed(changed_b), .button_pressed(pressed_b),
    .water_conflict(conflict_b), .sample_tick(tick_b)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0] m_stable;
  logic       m_changed;
  logic [1:0] m_pressed;
  int         m_edges;
  logic [7:0] m_raw_q[$];
  logic [7:0] m_samp_q[$];

  logic [10:0] actv;
  assign actv = {stable_sensors, sensor_changed, button_pressed, water_conflict, sample_tick};

  function automatic logic [10:0] expv();
    logic wc;
    logic tk;
    wc = (m_stable[2] & ~m_stable[1]) | (m_stable[1] & ~m_stable[0]) | (m_stable[2] & ~m_stable[0]);
    tk = reset_n && ((m_edges % SD) == SD - 1);
    return {m_stable[5:0], m_changed, m_pressed, wc, tk};
  endfunction

  task automatic model_clear();
    m_stable  = '0;
    m_changed = 1'b0;
    m_pressed = '0;
    m_edges   = 0;
    m_raw_q.delete();
    m_samp_q.delete();
  endtask

  // One clock: model update at the rising edge, return at the falling edge for sampling.
  task automatic step();
    logic [7:0] prev;
    logic [7:0] synced;
    @(posedge clock);
    prev = m_stable;
    if (reset_n) begin
      m_raw_q.push_back({raw_buttons, raw_sensors});
      m_edges++;
      if ((m_edges % SD) == 0) begin
        synced = (m_raw_q.size() >= 3) ? m_raw_q[m_raw_q.size() - 3] : 8'h00;
        m_samp_q.push_back(synced);
        for (int b = 0; b < 8; b++) begin
          bit flip;
          flip = (m_samp_q.size() >= DT);
          for (int j = 1; j <= DT; j++)
            if (flip && m_samp_q[m_samp_q.size() - j][b] == m_stable[b]) flip = 1'b0;
          if (flip) m_stable[b] = ~m_stable[b];
        end
        while (m_samp_q.size() > DT) void'(m_samp_q.pop_front());
      end
      while (m_raw_q.size() > 3) void'(m_raw_q.pop_front());
    end
    m_changed = (prev[5:0] != m_stable[5:0]);
    m_pressed = m_stable[7:6] & ~prev[7:6];
    @(negedge clock);
  endtask

  task automatic test_reset();
    raw_sensors = 6'b111111;
    raw_buttons = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (actv !== 11'h000) begin
        mismatched++;
        $display("FAIL reset_outputs: got %h expected %h", actv, 11'h000);
      end
      compared++;
      if ({stable_b, changed_b, pressed_b, conflict_b, tick_b} !== 11'h000) begin
        mismatched++;
        $display("FAIL reset_fast_outputs: got %h expected %h",
                 {stable_b, changed_b, pressed_b, conflict_b, tick_b}, 11'h000);
      end
    end
  endtask

  task automatic test_power_up();
    int pulses;
    pulses = 0;
    raw_sensors = 6'b000111;
    raw_buttons = 2'b00;
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (sensor_changed === 1'b1) pulses++;
      compared++;
      if (actv !== expv()) begin
        mismatched++;
        $display("FAIL power_up_cycle%0d: got %h expected %h", i, actv, expv());
      end
    end
    compared++;
    if (pulses !== 1) begin
      mismatched++;
      $display("FAIL power_up_pulses: got %0d expected 1", pulses);
    end
    compared++;
    if ({stable_sensors, water_conflict} !== {6'b000111, 1'b0}) begin
      mismatched++;
      $display("FAIL power_up_final: got %b expected %b", {stable_sensors, water_conflict}, 7'b0001110);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    raw_sensors = 6'b000110;
    for (int i = 0; i < 28; i++) begin
      if (i == 2 * SD) raw_sensors = 6'b000111;
      step();
      if (sensor_changed === 1'b1) pulses++;
      compared++;
      if (actv !== expv()) begin
        mismatched++;
        $display("FAIL glitch_cycle%0d: got %h expected %h", i, actv, expv());
      end
    end
    compared++;
    if ({pulses, stable_sensors} !== {32'd0, 6'b000111}) begin
      mismatched++;
      $display("FAIL glitch_held: got pulses=%0d stable=%b expected pulses=0 stable=000111", pulses, stable_sensors);
    end
  endtask

  task automatic test_button();
    int p0;
    int p1;
    p0 = 0;
    p1 = 0;
    raw_buttons = 2'b01;
    for (int i = 0; i < 80; i++) begin
      if (i == 40) raw_buttons = 2'b00;
      step();
      if (button_pressed[0] === 1'b1) p0++;
      if (button_pressed[1] !== 1'b0) p1++;
      compared++;
      if (actv !== expv()) begin
        mismatched++;
        $display("FAIL button_cycle%0d: got %h expected %h", i, actv, expv());
      end
    end
    compared++;
    if (p0 !== 1 || p1 !== 0) begin
      mismatched++;
      $display("FAIL button_pulses: got p0=%0d p1=%0d expected p0=1 p1=0", p0, p1);
    end
  endtask

  task automatic test_water();
    raw_sensors = 6'b000100;
    for (int i = 0; i < 20; i++) step();
    compared++;
    if ({stable_sensors, water_conflict} !== {6'b000100, 1'b1}) begin
      mismatched++;
      $display("FAIL water_conflict_set: got %b expected %b", {stable_sensors, water_conflict}, 7'b0001001);
    end
    raw_sensors = 6'b000111;
    for (int i = 0; i < 20; i++) step();
    compared++;
    if ({stable_sensors, water_conflict} !== {6'b000111, 1'b0}) begin
      mismatched++;
      $display("FAIL water_conflict_clear: got %b expected %b", {stable_sensors, water_conflict}, 7'b0001110);
    end
  endtask

  task automatic test_reset_mid();
    bit reached;
    reached = 1'b0;
    raw_sensors = 6'b101010;
    for (int i = 0; i < 20 && !reached; i++) begin
      step();
      if (m_samp_q.size() >= 2 && m_samp_q[m_samp_q.size() - 1][5:0] == 6'b101010 &&
          m_samp_q[m_samp_q.size() - 2][5:0] == 6'b101010)
        reached = 1'b1;
    end
    compared++;
    if (!reached) begin
      mismatched++;
      $display("FAIL reset_mid_setup: got no two-sample run expected one within 20 cycles");
    end
    compared++;
    if (stable_sensors !== 6'b000111) begin
      mismatched++;
      $display("FAIL reset_mid_before: got %b expected 000111", stable_sensors);
    end
    reset_n = 1'b0;
    model_clear();
    #1;
    compared++;
    if (actv !== 11'h000) begin
      mismatched++;
      $display("FAIL reset_mid_async: got %h expected %h", actv, 11'h000);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      compared++;
      if (actv !== expv()) begin
        mismatched++;
        $display("FAIL reset_mid_cycle%0d: got %h expected %h", i, actv, expv());
      end
      if (i == 10) begin
        compared++;
        if (stable_sensors !== 6'b000000) begin
          mismatched++;
          $display("FAIL reset_mid_partial: got %b expected 000000", stable_sensors);
        end
      end
    end
    compared++;
    if (stable_sensors !== 6'b101010) begin
      mismatched++;
      $display("FAIL reset_mid_after: got %b expected 101010", stable_sensors);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 900; i++) begin
      if (hold == 0) begin
        raw_sensors = 6'($urandom);
        raw_buttons = 2'($urandom);
        hold = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8) : $urandom_range(10, 30);
      end
      hold--;
      step();
      compared++;
      if (actv !== expv()) begin
        mismatched++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, actv, expv());
      end
    end
  endtask

  task automatic test_fast();
    logic [7:0] exp_b;
    reset_b_n = 1'b1;
    raw_b = 6'b000001;
    for (int e = 1; e <= 4; e++) begin
      step();
      exp_b = {(e >= 3) ? 6'b000001 : 6'b000000, e == 3, 1'b1};
      compared++;
      if ({stable_b, changed_b, tick_b} !== exp_b) begin
        mismatched++;
        $display("FAIL fast_edge%0d: got %b expected %b", e, {stable_b, changed_b, tick_b}, exp_b);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    reset_b_n = 1'b0;
    raw_sensors = '0;
    raw_buttons = '0;
    raw_b = '0;
    model_clear();
    @(negedge clock);
    test_reset();
    test_power_up();
    test_glitch();
    test_button();
    test_water();
    test_reset_mid();
    test_random();
    test_fast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sensor_input_conditioner.md
SENSOR_INPUT_CONDITIONER -- requirements
Module: sensor_input_conditioner

Interface
REQ-001 Parameter SAMPLE_DIV, default 1024: clock cycles per debounce sample tick; legal range >= 1.
REQ-002 Parameter DEBOUNCE_TICKS, default 4: consecutive differing samples needed to accept a new level; legal range >= 1.
REQ-003 clock  in  1  single system clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 raw_sensors  in  6  unsynchronised sensor inputs; bit order {low_temperature, air_humidity, earth_humidity, high_water_level, mid_water_level, low_water_level} = [5:0].
REQ-006 raw_buttons  in  2  unsynchronised active-high push buttons; bit order {pulse_3, pulse_2} = [1:0].
REQ-007 stable_sensors  out  6  debounced sensor levels, same bit order as raw_sensors.
REQ-008 sensor_changed  out  1  one-cycle pulse when any stable_sensors bit changes.
REQ-009 button_pressed  out  2  one-cycle pulse per bit on a debounced button press.
REQ-010 water_conflict  out  1  inconsistent debounced water-level combination.
REQ-011 sample_tick  out  1  one-cycle debounce sample strobe, exported for display timing.

Function
REQ-012 All 8 raw bits SHALL pass through a 2-flop synchroniser before any other use.
REQ-013 The prescaler SHALL count 0..SAMPLE_DIV-1 and wrap to 0.
REQ-014 sample_tick SHALL be high for exactly the cycle in which the prescaler equals SAMPLE_DIV-1.
REQ-015 With SAMPLE_DIV=1, sample_tick SHALL be high every cycle.
REQ-016 Each of the 8 channels SHALL hold a stable bit and a counter of width clog2(DEBOUNCE_TICKS+1); the counter SHALL NOT wrap.
REQ-017 On a sample_tick where synced bit equals stable bit, the channel counter SHALL clear to 0.
REQ-018 On a sample_tick where synced bit differs and counter < DEBOUNCE_TICKS-1, the counter SHALL increment by 1.
REQ-019 On a sample_tick where synced bit differs and counter = DEBOUNCE_TICKS-1, stable SHALL take the synced value and the counter SHALL clear to 0.
REQ-020 Between sample ticks, stable bits and counters SHALL hold their values.
REQ-021 A glitch shorter than DEBOUNCE_TICKS consecutive samples SHALL leave the stable bit unchanged.
REQ-022 Acceptance latency from a raw edge SHALL be 2 synchroniser cycles plus the DEBOUNCE_TICKS-th qualifying sample tick.
REQ-023 Worst-case acceptance latency SHALL be at most 2 + SAMPLE_DIV*DEBOUNCE_TICKS cycles.
REQ-024 sensor_changed SHALL be high for exactly the first cycle in which a new stable_sensors value is visible.
REQ-025 Simultaneous changes in several sensor bits SHALL yield a single sensor_changed pulse.
REQ-026 Debounced button channels SHALL NOT affect sensor_changed.
REQ-027 button_pressed[i] SHALL be high for exactly the first cycle in which stable button i is visible as 1 after being 0.
REQ-028 A debounced button release SHALL produce no pulse.
REQ-029 A button held indefinitely SHALL produce exactly one button_pressed pulse.
REQ-030 water_conflict SHALL be a combinational function of registered stable bits only.
REQ-031 water_conflict SHALL be 1 when (high & ~mid) | (mid & ~low) | (high & ~low), and 0 otherwise.

Reset
REQ-032 While reset_n = 0, synchroniser flops, prescaler, counters, stable bits and every output SHALL be 0, effective immediately and independent of clock.
REQ-033 Assertion of reset_n mid-debounce SHALL discard partial counts.
REQ-034 On reset_n release, the prescaler SHALL start from 0.
REQ-035 Inputs already high at reset release SHALL be accepted through normal debounce and SHALL produce the corresponding sensor_changed or button_pressed pulse.

Verification (SAMPLE_DIV=4, DEBOUNCE_TICKS=3 unless stated)
REQ-036 Release reset with raw_sensors=6'b000111 held -> stable_sensors=000111 within 14 cycles, one sensor_changed pulse, water_conflict=0.
REQ-037 Stable at 000111, raw bit0 low for 2 sample periods then high again -> stable_sensors unchanged, no sensor_changed pulse.
REQ-038 raw_buttons[0] high for 40 cycles then low -> exactly one button_pressed[0] pulse, none on release, button_pressed[1]=0 throughout.
REQ-039 raw_sensors=6'b000100 held -> after debounce, stable_sensors=000100 and water_conflict=1; then raw=000111 -> water_conflict returns to 0 after debounce.
REQ-040 reset_n pulsed low for 1 cycle while a counter is at 2 -> all outputs 0 at once; a full 3-sample debounce is required afterwards.
REQ-041 SAMPLE_DIV=1, DEBOUNCE_TICKS=1, raw bit toggles at cycle 0 -> stable bit changes after the 3rd rising edge, with sensor_changed high in that same cycle.
